coax_rx_buffer: RTL and testbench

// - Receive-side message buffer, directly downstream of coax_rx. Captures received 10-bit words
//   and receiver error events, tags message starts, stores them in a FWFT FIFO and hands them
//   to the host interface through a simple pop handshake.
// - Detects FIFO overflow and drops the rest of the message. Records the loss as an error entry.

---
 rtl/coax_rx_buffer_pkg.sv | 42 ++++
 rtl/coax_rx_buffer_if.sv | 30 +++
 rtl/coax_rx_buffer_fifo.sv | 52 +++++
 rtl/coax_rx_buffer.sv | 103 ++++++++++
 tb/tb_coax_rx_buffer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/coax_rx_buffer_pkg.sv
// Shared definitions for the coax receive buffer: receiver error codes, entry layout,
// FSM state encoding and entry-formatting helpers.
package coax_rx_buffer_pkg;

    localparam logic [3:0] ERR_PARITY          = 4'd1;
    localparam logic [3:0] ERR_INVALID_END     = 4'd2;
    localparam logic [3:0] ERR_LOSS_OF_MID_BIT = 4'd3;
    localparam logic [3:0] ERR_OVERFLOW        = 4'd8;

    localparam int DATA_WIDTH    = 10;
    localparam int CODE_WIDTH    = 4;
    localparam int ENTRY_WIDTH   = 12;
    localparam int ENTRY_ERR_BIT = 11;
    localparam int ENTRY_SOM_BIT = 10;

    typedef logic [ENTRY_WIDTH-1:0] entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVING,
        ST_DISCARD,
        ST_FLUSH
    } rx_state_t;

    function automatic entry_t data_entry(input logic first, input logic [DATA_WIDTH-1:0] data);
        entry_t e;
        e                   = '0;
        e[ENTRY_SOM_BIT]    = first;
        e[DATA_WIDTH-1:0]   = data;
        return e;
    endfunction

    function automatic entry_t error_entry(input logic first, input logic [CODE_WIDTH-1:0] code);
        entry_t e;
        e                   = '0;
        e[ENTRY_ERR_BIT]    = 1'b1;
        e[ENTRY_SOM_BIT]    = first;
        e[CODE_WIDTH-1:0]   = code;
        return e;
    endfunction

endpackage

// File: rtl/coax_rx_buffer_if.sv
// Receiver-side and host-side signals of the coax receive buffer.
// The buffer itself uses the slave modport; the receiver/host side uses master.
interface coax_rx_buffer_if #(parameter int DEPTH = 256);
    import coax_rx_buffer_pkg::*;

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic                  rx_active;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_data_strobe;
    logic                  rx_error;
    logic [CODE_WIDTH-1:0] rx_error_code;
    logic                  read_strobe;
    entry_t                read_data;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;

    modport master (
        output rx_active, rx_data, rx_data_strobe, rx_error, rx_error_code, read_strobe,
        input  read_data, empty, full, count, overflow
    );

    modport slave (
        input  rx_active, rx_data, rx_data_strobe, rx_error, rx_error_code, read_strobe,
        output read_data, empty, full, count, overflow
    );

endinterface

// File: rtl/coax_rx_buffer_fifo.sv
// Generic first-word-fall-through FIFO. Pushes are refused when full unless a pop
// happens in the same cycle; pops are ignored when empty.
module coax_rx_buffer_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Empty head reads as zero so the output is defined straight out of reset.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/coax_rx_buffer.sv
// Receive message buffer: formats received words and error events into tagged entries,
// queues them in a FWFT FIFO and turns FIFO overflow into a recorded error entry.
//
// state     | meaning
// IDLE      | between messages; next word or error opens a message (first=1)
// RECEIVING | inside a message, words stored with first=0
// DISCARD   | message aborted; ignore strobes until rx_active falls
// FLUSH     | overflow pending; waiting for space to store the overflow entry
module coax_rx_buffer #(
    parameter int DEPTH = 256
) (
    input logic              clk,
    input logic              reset,
    coax_rx_buffer_if.slave  bus
);
    import coax_rx_buffer_pkg::*;

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    rx_state_t           r_state;
    logic                r_push;
    entry_t              r_entry;
    logic                r_overflow;
    logic                r_pending;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_drop;
    logic [ADDR_WIDTH:0] w_count;
    entry_t              w_head;

    assign w_pop  = bus.read_strobe && !w_empty;
    assign w_drop = r_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_push     <= 1'b0;
            r_entry    <= '0;
            r_overflow <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_push <= 1'b0;
            // A refused push aborts whatever the FSM was doing this cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_pending  <= 1'b1;
                r_state    <= ST_DISCARD;
            end else begin
                case (r_state)
                    ST_IDLE, ST_RECEIVING: begin
                        if (bus.rx_error) begin
                            r_push  <= 1'b1;
                            r_entry <= error_entry(r_state == ST_IDLE, bus.rx_error_code);
                            r_state <= ST_DISCARD;
                        end else if (bus.rx_data_strobe) begin
                            r_push  <= 1'b1;
                            r_entry <= data_entry(r_state == ST_IDLE, bus.rx_data);
                            r_state <= ST_RECEIVING;
                        end else if (!bus.rx_active) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DISCARD: begin
                        if (!bus.rx_active) r_state <= r_pending ? ST_FLUSH : ST_IDLE;
                    end
                    ST_FLUSH: begin
                        if (!w_full || w_pop) begin
                            r_push    <= 1'b1;
                            r_entry   <= error_entry(1'b0, ERR_OVERFLOW);
                            r_pending <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    coax_rx_buffer_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (r_push),
        .i_pop     (bus.read_strobe),
        .i_wr_data (r_entry),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign bus.read_data = w_head;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Bench for coax_rx_buffer at DEPTH=4: directed message scenarios followed by random
// traffic, all checked every cycle against a queue-based reference of the buffer.
module tb_coax_rx_buffer;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    coax_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

    coax_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: stored entries as a queue plus message-level flags.
    logic [11:0] mq[$];
    bit          m_ovf, m_pend, m_inmsg, m_disc, m_flush;
    bit          m_pv;
    logic [11:0] m_pval;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_pend = 0; m_inmsg = 0; m_disc = 0; m_flush = 0;
        m_pv = 0; m_pval = '0;
    endtask

    task automatic model_step();
        int          sz0;
        bit          pop, drop, np;
        logic [11:0] nv;
        sz0  = mq.size();
        pop  = bus.read_strobe && (sz0 > 0);
        drop = m_pv && (sz0 == DEPTH) && !pop;
        np   = 0;
        nv   = '0;
        if (pop) void'(mq.pop_front());
        if (m_pv && !drop) mq.push_back(m_pval);
        if (drop) begin
            m_ovf = 1; m_pend = 1; m_disc = 1; m_flush = 0; m_inmsg = 0;
        end else if (m_flush) begin
            if (sz0 < DEPTH || pop) begin
                np = 1; nv = 12'h808; m_pend = 0; m_flush = 0;
            end
        end else if (m_disc) begin
            if (!bus.rx_active) begin
                m_disc = 0; m_flush = m_pend;
            end
        end else if (bus.rx_error) begin
            np = 1; nv = {1'b1, !m_inmsg, 6'b0, bus.rx_error_code};
            m_disc = 1; m_inmsg = 0;
        end else if (bus.rx_data_strobe) begin
            np = 1; nv = {1'b0, !m_inmsg, bus.rx_data};
            m_inmsg = 1;
        end else if (!bus.rx_active) begin
            m_inmsg = 0;
        end
        m_pv   = np;
        m_pval = nv;
    endtask

    task automatic compare_all();
        check("count",    32'(bus.count),     32'(mq.size()));
        check("empty",    32'(bus.empty),     32'(mq.size() == 0));
        check("full",     32'(bus.full),      32'(mq.size() == DEPTH));
        check("overflow", 32'(bus.overflow),  32'(m_ovf));
        check("head",     32'(bus.read_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        bus.rx_data_strobe = 1'b0;
        bus.rx_error       = 1'b0;
        bus.read_strobe    = 1'b0;
        compare_all();
    endtask

    task automatic send_word(input logic [9:0] w);
        bus.rx_data        = w;
        bus.rx_data_strobe = 1'b1;
        tick();
    endtask

    task automatic pop_one();
        bus.read_strobe = 1'b1;
        tick();
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    initial begin
        reset              = 1'b1;
        bus.rx_active      = 1'b0;
        bus.rx_data        = '0;
        bus.rx_data_strobe = 1'b0;
        bus.rx_error       = 1'b0;
        bus.rx_error_code  = '0;
        bus.read_strobe    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_data",  32'(bus.read_data), 32'd0);

        // Three-word message, then drain.
        bus.rx_active = 1'b1;
        send_word(10'h2A5);
        send_word(10'h001);
        send_word(10'h3FF);
        bus.rx_active = 1'b0;
        tick();
        check("msg3_count", 32'(bus.count), 32'd3);
        check("msg3_e0", 32'(bus.read_data), 32'h6A5);
        pop_one();
        check("msg3_e1", 32'(bus.read_data), 32'h001);
        pop_one();
        check("msg3_e2", 32'(bus.read_data), 32'h3FF);
        pop_one();
        check("msg3_empty", 32'(bus.empty), 32'd1);

        // Error mid-message discards the rest; next message starts fresh.
        bus.rx_active = 1'b1;
        send_word(10'h155);
        bus.rx_error      = 1'b1;
        bus.rx_error_code = 4'd1;
        tick();
        send_word(10'h0AA);
        bus.rx_active = 1'b0;
        tick();
        check("err_count", 32'(bus.count), 32'd2);
        check("err_e0", 32'(bus.read_data), 32'h555);
        pop_one();
        check("err_e1", 32'(bus.read_data), 32'h801);
        pop_one();
        bus.rx_active = 1'b1;
        send_word(10'h123);
        tick();
        check("err_next_first", 32'(bus.read_data), 32'h523);
        bus.rx_active = 1'b0;
        pop_one();
        tick();

        // Six-word message into a 4-deep FIFO: overflow and flush entry.
        bus.rx_active = 1'b1;
        for (int i = 0; i < 6; i++) send_word(10'(10'h100 + i));
        tick();
        check("ovf_count", 32'(bus.count), 32'd4);
        check("ovf_full",  32'(bus.full), 32'd1);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        bus.rx_active = 1'b0;
        tick();
        pop_one();
        tick();
        check("ovf_refill", 32'(bus.count), 32'd4);
        check("ovf_head",   32'(bus.read_data), 32'h101);
        pop_one();
        pop_one();
        pop_one();
        check("ovf_tail", 32'(bus.read_data), 32'h808);
        pop_one();

        // Full FIFO with push and pop in the same cycle.
        sync_reset();
        bus.rx_active = 1'b1;
        for (int i = 0; i < 5; i++) send_word(10'(10'h0A0 + i));
        check("full_before", 32'(bus.count), 32'd4);
        pop_one();
        check("full_pp_count", 32'(bus.count), 32'd4);
        check("full_pp_ovf",   32'(bus.overflow), 32'd0);
        check("full_pp_head",  32'(bus.read_data), 32'h0A1);
        bus.rx_active = 1'b0;
        tick();
        pop_one();
        pop_one();
        pop_one();
        check("full_pp_tail", 32'(bus.read_data), 32'h0A4);
        pop_one();

        // Pop request on an empty FIFO in the push cycle is ignored.
        bus.rx_active = 1'b1;
        send_word(10'h3C3);
        pop_one();
        check("empty_pp_count", 32'(bus.count), 32'd1);
        check("empty_pp_head",  32'(bus.read_data), 32'h7C3);
        bus.rx_active = 1'b0;
        pop_one();

        // Random traffic, reads slower then faster than writes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) bus.rx_active = !bus.rx_active;
            if (bus.rx_active) begin
                bus.rx_data_strobe = ($urandom_range(0, 2) == 0);
                bus.rx_error       = ($urandom_range(0, 19) == 0);
                bus.rx_data        = 10'($urandom);
                bus.rx_error_code  = 4'($urandom_range(1, 3));
            end
            bus.read_strobe = ($urandom_range(0, (i < 300) ? 3 : 1) == 0);
            tick();
        end
        bus.rx_active = 1'b0;
        for (int i = 0; i < 12; i++) pop_one();
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Asynchronous reset between clock edges with two entries stored.
        bus.rx_active = 1'b1;
        send_word(10'h011);
        send_word(10'h012);
        tick();
        check("ar_before", 32'(bus.count), 32'd2);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("ar_empty", 32'(bus.empty), 32'd1);
        check("ar_count", 32'(bus.count), 32'd0);
        check("ar_ovf",   32'(bus.overflow), 32'd0);
        check("ar_data",  32'(bus.read_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();
        send_word(10'h2B4);
        tick();
        check("ar_first", 32'(bus.read_data), 32'h6B4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
